// File: rtl/picorv_loader_pkg.sv
// Shared types and constants for the picorv32 boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package picorv_loader_pkg;

  // Response byte widths on the serial side.
  localparam int ACK_W = 8;
  localparam int NAK_W = 8;

  // Framing and response characters.
  localparam logic [7:0] CH_S = 8'h53;  // 'S' start of frame / reload request
  localparam logic [7:0] CH_K = 8'h4B;  // 'K' image accepted
  localparam logic [7:0] CH_E = 8'h45;  // 'E' image rejected

  // Loader FSM; the encoding is exported on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RESP   = 3'd5,
    ST_RUN    = 3'd6
  } state_t;

  // One SRAM command beat, shared by the loader and core paths.
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/loader_core_port.sv
// Run-mode memory port for the core: address decode to SRAM / LED register / default.
// Latency: access issued in the valid cycle, mem_ready exactly one cycle later.
// Backpressure: none; every access completes in one cycle, en low aborts a pending ready.
module loader_core_port
  import picorv_loader_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          LED_W    = 8,
  parameter logic [31:0] LED_ADDR = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  logic              core_mem_valid,
  input  logic [31:0]       core_mem_addr,
  input  logic [31:0]       core_mem_wdata,
  input  logic [3:0]        core_mem_wstrb,
  output logic [31:0]       core_mem_rdata,
  output logic              core_mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output sram_cmd_t         sram_cmd,
  input  logic [31:0]       sram_rdata,
  output logic [LED_W-1:0]  leds
);

  logic        ready_q;
  logic        rd_sram_q;
  logic [31:0] rd_hold_q;
  logic        take;
  logic        hit_sram;
  logic        hit_led;
  logic        is_rd;

  // A new access is accepted only when no ready is pending, so ready never lasts two cycles.
  assign take     = en && core_mem_valid && !ready_q;
  assign hit_sram = (core_mem_addr[31:ADDR_W+2] == '0);
  assign hit_led  = !hit_sram && (core_mem_addr == LED_ADDR);
  assign is_rd    = (core_mem_wstrb == 4'b0000);

  // Drive the SRAM only for an accepted access that decodes into the SRAM window.
  always_comb begin
    sram_addr = '0;
    sram_cmd  = '0;
    if (take && hit_sram) begin
      sram_addr      = core_mem_addr[ADDR_W+1:2];
      sram_cmd.wr    = !is_rd;
      sram_cmd.rd    = is_rd;
      sram_cmd.be    = core_mem_wstrb;
      sram_cmd.wdata = core_mem_wdata;
    end
  end

  // One-cycle ready generator plus the source of the read data for that ready cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      ready_q   <= 1'b0;
      rd_sram_q <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      ready_q   <= take;
      rd_sram_q <= take && hit_sram && is_rd;
      rd_hold_q <= (take && hit_led && is_rd) ? 32'(leds) : 32'd0;
    end
  end

  // LED register; only byte lane 0 of a write reaches it.
  always_ff @(posedge clk) begin
    if (RST) begin
      leds <= '0;
    end else if (take && hit_led && core_mem_wstrb[0]) begin
      leds <= core_mem_wdata[LED_W-1:0];
    end
  end

  // Ready is masked by en so a reload in the ready cycle still suppresses it.
  assign core_mem_ready = ready_q && en;

  // Read data is forced to zero outside the ready cycle.
  always_comb begin
    core_mem_rdata = 32'd0;
    if (core_mem_ready) begin
      core_mem_rdata = rd_sram_q ? sram_rdata : rd_hold_q;
    end
  end

endmodule

// File: rtl/picorv_loader.sv
// Boot loader: framed byte stream -> SRAM image, checksum/length check, ack byte, core release.
// Latency: SRAM write in the rx_valid cycle; ack one cycle after CSUM unless tx_busy stalls it.
// Backpressure: only tx_busy (holds RESP); rx bytes are never stalled, bytes in RESP are dropped.
module picorv_loader
  import picorv_loader_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          LED_W       = 8,
  parameter logic [31:0] LED_ADDR    = 32'h1000_0000,
  parameter int          RELOAD_EN   = 1,
  parameter int          TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_be,
  output logic              sram_wr_en,
  output logic              sram_rd_en,
  input  logic [31:0]       sram_rdata,
  output logic              core_resetn,
  input  logic              core_mem_valid,
  input  logic [31:0]       core_mem_addr,
  input  logic [31:0]       core_mem_wdata,
  input  logic [3:0]        core_mem_wstrb,
  output logic [31:0]       core_mem_rdata,
  output logic              core_mem_ready,
  output logic [LED_W-1:0]  leds,
  output logic [2:0]        state_dbg
);

  state_t              state_q;
  logic [7:0]          len_hi_q;
  logic [ADDR_W-1:0]   last_word_q;
  logic [ADDR_W-1:0]   word_ptr_q;
  logic [1:0]          lane_q;
  logic [7:0]          csum_q;
  logic [ACK_W-1:0]    resp_q;
  logic [31:0]         tmo_cnt_q;

  logic                rx_s;
  logic                reload_hit;
  logic                run_en;
  logic                load_state;
  logic                tmo_hit;
  logic [15:0]         len_w;
  logic                len_bad;
  logic                ld_wr;
  logic [ADDR_W-1:0]   cp_addr;
  sram_cmd_t           cp_cmd;

  assign rx_s       = rx_valid && (rx_data == CH_S);
  assign reload_hit = (RELOAD_EN != 0) && (state_q == ST_RUN) && rx_s;
  // The reload byte releases the core bus and reasserts core reset in its own cycle.
  assign run_en     = (state_q == ST_RUN) && !reload_hit;
  assign core_resetn = run_en;

  assign load_state = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign tmo_hit    = (TIMEOUT_CYC != 0) && load_state && !rx_valid &&
                      (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));

  assign len_w   = {len_hi_q, rx_data};
  assign len_bad = (len_w == 16'd0) || ({16'd0, len_w} > (32'd1 << ADDR_W));

  assign ld_wr    = (state_q == ST_DATA) && rx_valid;
  assign tx_start = (state_q == ST_RESP) && !tx_busy;
  assign tx_data  = resp_q;
  assign state_dbg = state_q;

  loader_core_port #(
    .ADDR_W  (ADDR_W),
    .LED_W   (LED_W),
    .LED_ADDR(LED_ADDR)
  ) u_core_port (
    .clk           (clk),
    .RST           (RST),
    .en            (run_en),
    .core_mem_valid(core_mem_valid),
    .core_mem_addr (core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .core_mem_wstrb(core_mem_wstrb),
    .core_mem_rdata(core_mem_rdata),
    .core_mem_ready(core_mem_ready),
    .sram_addr     (cp_addr),
    .sram_cmd      (cp_cmd),
    .sram_rdata    (sram_rdata),
    .leds          (leds)
  );

  // SRAM owner is the core port in RUN, otherwise the loader's single-lane byte writes.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = 32'd0;
    sram_be    = 4'b0000;
    sram_wr_en = 1'b0;
    sram_rd_en = 1'b0;
    if (state_q == ST_RUN) begin
      sram_addr  = cp_addr;
      sram_wdata = cp_cmd.wdata;
      sram_be    = cp_cmd.be;
      sram_wr_en = cp_cmd.wr;
      sram_rd_en = cp_cmd.rd;
    end else if (ld_wr) begin
      sram_addr  = word_ptr_q;
      sram_wdata = {4{rx_data}};
      sram_be    = 4'b0001 << lane_q;
      sram_wr_en = 1'b1;
    end
  end

  // Inter-byte idle counter; restarts on every byte and outside the loading states.
  always_ff @(posedge clk) begin
    if (RST) begin
      tmo_cnt_q <= 32'd0;
    end else if (rx_valid || !load_state) begin
      tmo_cnt_q <= 32'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  // Frame parser, pointer/checksum tracking and the ack/run sequencing.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= 8'd0;
      last_word_q <= '0;
      word_ptr_q  <= '0;
      lane_q      <= 2'd0;
      csum_q      <= 8'd0;
      resp_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_s) begin
            state_q    <= ST_LEN_HI;
            len_hi_q   <= 8'd0;
            word_ptr_q <= '0;
            lane_q     <= 2'd0;
            csum_q     <= 8'd0;
          end
        end
        ST_LEN_HI: begin
          if (tmo_hit) begin
            resp_q  <= CH_E;
            state_q <= ST_RESP;
          end else if (rx_valid) begin
            len_hi_q <= rx_data;
            state_q  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (tmo_hit) begin
            resp_q  <= CH_E;
            state_q <= ST_RESP;
          end else if (rx_valid) begin
            if (len_bad) begin
              resp_q  <= CH_E;
              state_q <= ST_RESP;
            end else begin
              last_word_q <= ADDR_W'(len_w - 16'd1);
              state_q     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tmo_hit) begin
            resp_q  <= CH_E;
            state_q <= ST_RESP;
          end else if (rx_valid) begin
            csum_q <= csum_q + rx_data;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              if (word_ptr_q == last_word_q) begin
                state_q <= ST_CSUM;
              end else begin
                word_ptr_q <= word_ptr_q + ADDR_W'(1);
              end
            end
          end
        end
        ST_CSUM: begin
          if (tmo_hit) begin
            resp_q  <= CH_E;
            state_q <= ST_RESP;
          end else if (rx_valid) begin
            resp_q  <= (rx_data == csum_q) ? CH_K : CH_E;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!tx_busy) begin
            state_q <= (resp_q == CH_K) ? ST_RUN : ST_IDLE;
          end
        end
        ST_RUN: begin
          if (reload_hit) begin
            state_q    <= ST_LEN_HI;
            len_hi_q   <= 8'd0;
            word_ptr_q <= '0;
            lane_q     <= 2'd0;
            csum_q     <= 8'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
